dp_share_arbiter: RTL and testbench

//   Shares one instance of the combinational 4-operand datapath (top: in1..in4 -> out1)

---
 rtl/dp_share_arbiter_if.sv | 35 +++
 rtl/dp_share_arbiter.sv | 113 +++++++++++
 tb/tb_dp_share_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_share_arbiter_if.sv
// Bundles the requester, response and shared-datapath signals of dp_share_arbiter.
// No latency of its own: wires only.
// Backpressure: request valid/ready per requester, response valid/ready.
interface dp_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_ops;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_ops;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [33:0] rsp_data;
    logic [15:0] dp_in1;
    logic [15:0] dp_in2;
    logic [15:0] dp_in3;
    logic [15:0] dp_in4;
    logic [33:0] dp_out1;
    logic        busy;

    // Requesters, response consumer and datapath result as seen from outside the arbiter
    modport master (
        output req0_valid, req0_ops, req1_valid, req1_ops, rsp_ready, dp_out1,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        input  dp_in1, dp_in2, dp_in3, dp_in4, busy
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_ops, req1_valid, req1_ops, rsp_ready, dp_out1,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        output dp_in1, dp_in2, dp_in3, dp_in4, busy
    );
endinterface

// File: rtl/dp_share_arbiter.sv
// Round-robin share of one combinational 4-operand datapath between two requesters.
// Latency: rsp_valid rises WAIT_CYCLES cycles after accept; one bubble cycle after response.
// Backpressure: requests wait in IDLE-only accept; response held indefinitely until rsp_ready.
module dp_share_arbiter #(
    parameter int WAIT_CYCLES = 2   // operand launch to result capture, legal 1..15
) (
    input  logic               clk,
    input  logic               rst,
    dp_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
    } ops_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t state;
    state_t state_nxt;
    logic [3:0] cnt;
    logic       last;
    logic       grant;
    logic       rdy0;
    logic       rdy1;
    logic       accept;
    ops_t       ops_sel;

    // Round-robin pick: a lone requester wins, on a tie the one not served last wins
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    // Readies gated by rst so they drop the moment reset asserts, not at the next edge
    assign rdy0    = ~rst & (state == IDLE) & ~grant & bus.req0_valid;
    assign rdy1    = ~rst & (state == IDLE) &  grant & bus.req1_valid;
    assign accept  = rdy0 | rdy1;
    assign ops_sel = grant ? ops_t'(bus.req1_ops) : ops_t'(bus.req0_ops);

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.busy       = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: accept -> settle countdown -> hold response until consumed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0)   state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand launch, settle counter, result capture and response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 4'd0;
            last         <= 1'b1;
            bus.dp_in1   <= 16'd0;
            bus.dp_in2   <= 16'd0;
            bus.dp_in3   <= 16'd0;
            bus.dp_in4   <= 16'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= 34'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.dp_in1 <= ops_sel.a;
                        bus.dp_in2 <= ops_sel.b;
                        bus.dp_in3 <= ops_sel.c;
                        bus.dp_in4 <= ops_sel.d;
                        bus.rsp_id <= grant;
                        last       <= grant;
                        cnt        <= CNT_INIT;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rsp_data  <= bus.dp_out1;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready)
                        bus.rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed bench for dp_share_arbiter: three instances cover WAIT_CYCLES = 2, 4 and 1.
// Each instance gets a behavioural datapath out1 = in1*in2 + in3*in4.
// Expected values are hand-computed constants.
module tb_dp_share_arbiter;

    logic clk;
    logic rst;
    int   cmp_cnt;
    int   err_cnt;

    dp_share_arbiter_if if2();
    dp_share_arbiter_if if4();
    dp_share_arbiter_if if1();

    dp_share_arbiter #(.WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst), .bus(if2.slave));
    dp_share_arbiter #(.WAIT_CYCLES(4)) u_w4 (.clk(clk), .rst(rst), .bus(if4.slave));
    dp_share_arbiter #(.WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if2.dp_out1 = 34'(if2.dp_in1) * 34'(if2.dp_in2) + 34'(if2.dp_in3) * 34'(if2.dp_in4);
    assign if4.dp_out1 = 34'(if4.dp_in1) * 34'(if4.dp_in2) + 34'(if4.dp_in3) * 34'(if4.dp_in4);
    assign if1.dp_out1 = 34'(if1.dp_in1) * 34'(if1.dp_in2) + 34'(if1.dp_in3) * 34'(if1.dp_in4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    // Present ops on requester id of the W=2 instance, wait for ready, then drop valid after accept
    task automatic send2(input string tag, input bit id, input logic [63:0] ops);
        int n;
        if (id) begin
            if2.req1_valid = 1'b1;
            if2.req1_ops   = ops;
        end else begin
            if2.req0_valid = 1'b1;
            if2.req0_ops   = ops;
        end
        #1;
        n = 0;
        while (!(id ? if2.req1_ready : if2.req0_ready) && n < 20) begin
            go;
            n++;
        end
        chk_eq({tag, "_ready"}, 64'(id ? if2.req1_ready : if2.req0_ready), 64'd1);
        go;
        if (id) if2.req1_valid = 1'b0;
        else    if2.req0_valid = 1'b0;
    endtask

    // Called just after an accept edge; measures latency to rsp_valid and checks the response
    task automatic wait_rsp2(input string tag, input bit exp_id, input logic [33:0] exp_data);
        int n;
        n = 0;
        while (!if2.rsp_valid && n < 20) begin
            go;
            n++;
        end
        chk_eq({tag, "_lat"},  64'(n), 64'd2);
        chk_eq({tag, "_id"},   64'(if2.rsp_id), 64'(exp_id));
        chk_eq({tag, "_data"}, 64'(if2.rsp_data), 64'(exp_data));
    endtask

    initial begin
        int  n;
        bit  seen;
        int  nacc;
        int  nrsp;
        int  last_cyc;
        bit  gid;

        cmp_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        if2.req0_valid = 1'b0; if2.req0_ops = 64'd0; if2.req1_valid = 1'b0; if2.req1_ops = 64'd0;
        if2.rsp_ready  = 1'b1;
        if4.req0_valid = 1'b0; if4.req0_ops = 64'd0; if4.req1_valid = 1'b0; if4.req1_ops = 64'd0;
        if4.rsp_ready  = 1'b1;
        if1.req0_valid = 1'b0; if1.req0_ops = 64'd0; if1.req1_valid = 1'b0; if1.req1_ops = 64'd0;
        if1.rsp_ready  = 1'b1;
        #12;
        rst = 1'b0;
        go;

        // Reset state
        chk_eq("rst_busy",     64'(if2.busy), 64'd0);
        chk_eq("rst_rsp_vld",  64'(if2.rsp_valid), 64'd0);
        chk_eq("rst_rsp_id",   64'(if2.rsp_id), 64'd0);
        chk_eq("rst_rsp_data", 64'(if2.rsp_data), 64'd0);
        chk_eq("rst_dp_in",    {if2.dp_in1, if2.dp_in2, if2.dp_in3, if2.dp_in4}, 64'd0);
        chk_eq("rst_ready",    64'({if2.req0_ready, if2.req1_ready}), 64'd0);

        // T1: single op 3*5 + 7*11 = 92
        send2("t1", 1'b0, {16'd3, 16'd5, 16'd7, 16'd11});
        chk_eq("t1_busy",  64'(if2.busy), 64'd1);
        chk_eq("t1_dp_in", {if2.dp_in1, if2.dp_in2, if2.dp_in3, if2.dp_in4},
               {16'd3, 16'd5, 16'd7, 16'd11});
        wait_rsp2("t1", 1'b0, 34'd92);
        go;
        chk_eq("t1_idle_vld",  64'(if2.rsp_valid), 64'd0);
        chk_eq("t1_idle_busy", 64'(if2.busy), 64'd0);

        // T2: tie right after reset -> req0 first (1*2+3*4=14), then req1 (5*6+7*8=86)
        rst = 1'b1;
        #1;
        rst = 1'b0;
        if2.req0_valid = 1'b1; if2.req0_ops = {16'd1, 16'd2, 16'd3, 16'd4};
        if2.req1_valid = 1'b1; if2.req1_ops = {16'd5, 16'd6, 16'd7, 16'd8};
        #1;
        chk_eq("t2_rdy0", 64'(if2.req0_ready), 64'd1);
        chk_eq("t2_rdy1", 64'(if2.req1_ready), 64'd0);
        go;
        if2.req0_valid = 1'b0;
        chk_eq("t2_rdy1_busy", 64'(if2.req1_ready), 64'd0);
        wait_rsp2("t2a", 1'b0, 34'd14);
        go;
        chk_eq("t2_rdy1_idle", 64'(if2.req1_ready), 64'd1);
        go;
        if2.req1_valid = 1'b0;
        wait_rsp2("t2b", 1'b1, 34'd86);
        go;

        // T3: all operands 0xFFFF -> 2 * 0xFFFE0001
        send2("t3", 1'b0, {4{16'hFFFF}});
        wait_rsp2("t3", 1'b0, 34'h1_FFFC_0002);
        go;

        // T4: backpressure for 10 cycles with a pending req0; 2*3+4*5 = 26
        if2.rsp_ready = 1'b0;
        send2("t4", 1'b1, {16'd2, 16'd3, 16'd4, 16'd5});
        wait_rsp2("t4", 1'b1, 34'd26);
        if2.req0_valid = 1'b1;
        if2.req0_ops   = {16'd10, 16'd10, 16'd0, 16'd0};
        for (int i = 0; i < 10; i++) begin
            go;
            chk_eq("t4_hold_vld",  64'(if2.rsp_valid), 64'd1);
            chk_eq("t4_hold_data", 64'(if2.rsp_data), 64'd26);
            chk_eq("t4_hold_id",   64'(if2.rsp_id), 64'd1);
            chk_eq("t4_hold_rdy",  64'({if2.req0_ready, if2.req1_ready}), 64'd0);
            chk_eq("t4_hold_dp",   {if2.dp_in1, if2.dp_in2, if2.dp_in3, if2.dp_in4},
                   {16'd2, 16'd3, 16'd4, 16'd5});
        end
        if2.rsp_ready = 1'b1;
        go;
        chk_eq("t4_rel_vld",  64'(if2.rsp_valid), 64'd0);
        chk_eq("t4_rel_busy", 64'(if2.busy), 64'd0);
        chk_eq("t4_rel_rdy0", 64'(if2.req0_ready), 64'd1);
        go;
        if2.req0_valid = 1'b0;
        wait_rsp2("t4b", 1'b0, 34'd100);
        go;

        // T5: WAIT_CYCLES=4, reset pulse two cycles into SETTLE
        if4.req0_valid = 1'b1;
        if4.req0_ops   = {16'd3, 16'd5, 16'd7, 16'd11};
        #1;
        chk_eq("t5_rdy0", 64'(if4.req0_ready), 64'd1);
        go;
        if4.req0_valid = 1'b0;
        go;
        go;
        chk_eq("t5_busy_pre", 64'(if4.busy), 64'd1);
        if4.req1_valid = 1'b1;
        if4.req1_ops   = {16'd1, 16'd1, 16'd1, 16'd1};
        rst = 1'b1;
        #1;
        chk_eq("t5_rst_busy", 64'(if4.busy), 64'd0);
        chk_eq("t5_rst_vld",  64'(if4.rsp_valid), 64'd0);
        chk_eq("t5_rst_id",   64'(if4.rsp_id), 64'd0);
        chk_eq("t5_rst_data", 64'(if4.rsp_data), 64'd0);
        chk_eq("t5_rst_dp",   {if4.dp_in1, if4.dp_in2, if4.dp_in3, if4.dp_in4}, 64'd0);
        chk_eq("t5_rst_rdy",  64'({if4.req0_ready, if4.req1_ready}), 64'd0);
        if4.req1_valid = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            go;
            seen = seen | if4.rsp_valid;
        end
        chk_eq("t5_no_rsp", 64'(seen), 64'd0);
        if4.req1_valid = 1'b1;
        #1;
        chk_eq("t5_rdy1", 64'(if4.req1_ready), 64'd1);
        go;
        if4.req1_valid = 1'b0;
        n = 0;
        while (!if4.rsp_valid && n < 20) begin
            go;
            n++;
        end
        chk_eq("t5_lat",  64'(n), 64'd4);
        chk_eq("t5_id",   64'(if4.rsp_id), 64'd1);
        chk_eq("t5_data", 64'(if4.rsp_data), 64'd2);
        go;

        // T6: WAIT_CYCLES=1 saturation; req0 -> 100*2+3*4=212, req1 -> 7*9+1*1=64
        if1.req0_valid = 1'b1; if1.req0_ops = {16'd100, 16'd2, 16'd3, 16'd4};
        if1.req1_valid = 1'b1; if1.req1_ops = {16'd7, 16'd9, 16'd1, 16'd1};
        if1.rsp_ready  = 1'b1;
        #1;
        nacc = 0;
        nrsp = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && nacc < 8; cyc++) begin
            if (if1.req0_ready || if1.req1_ready) begin
                chk_eq("t6_excl", 64'(if1.req0_ready & if1.req1_ready), 64'd0);
                gid = if1.req1_ready;
                chk_eq("t6_grant", 64'(gid), 64'(nacc % 2));
                if (nacc > 0)
                    chk_eq("t6_gap", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                nacc++;
            end
            if (if1.rsp_valid) begin
                chk_eq("t6_rsp_id",   64'(if1.rsp_id), 64'(nrsp % 2));
                chk_eq("t6_rsp_data", 64'(if1.rsp_data), (nrsp % 2 == 1) ? 64'd64 : 64'd212);
                nrsp++;
            end
            go;
        end
        chk_eq("t6_count", 64'(nacc), 64'd8);
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;
        go;
        go;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
